// File: rtl/mm_bus_pkg.sv
// mm_bus_pkg: shared types, widths and peripheral base addresses for the memory-mapped bus
package mm_bus_pkg;
  localparam int MM_ADDR_W = 32;
  localparam int MM_DATA_W = 32;
  localparam logic [MM_ADDR_W-1:0] LED_BASE = 32'h4000_0000;
  localparam logic [MM_ADDR_W-1:0] SW_BASE = 32'h4000_0100;
  localparam logic [MM_ADDR_W-1:0] UART_BASE = 32'h4000_0200;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef struct packed {
    logic we;
    logic [MM_ADDR_W-1:0] addr;
    logic [MM_DATA_W-1:0] wdata;
  } mm_req_t;
endpackage

// File: rtl/mm_timeout_ctr.sv
// mm_timeout_ctr: clearable cycle counter flagging the last allowed wait cycle
module mm_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = TIMEOUT_CYCLES > 2 ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt;
  // counts un-acked access cycles, restarting whenever the access ends
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  end
  assign expire = en && cnt == CW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/mm_bus_master.sv
// mm_bus_master: single-outstanding bus initiator; define MM_TIMEOUT_EN to abort accesses that never get an ack
module mm_bus_master
  import mm_bus_pkg::*;
#(
  parameter int ADDR_W = MM_ADDR_W,
  parameter int DATA_W = MM_DATA_W,
  parameter int TIMEOUT_CYCLES = 256,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              write_o,
  output logic              read_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ack_i
);
  state_t state;
  logic ack;
  logic expire;
  assign ack = ack_i == 1'b1;
`ifdef MM_TIMEOUT_EN
  mm_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk),
    .rst(rst),
    .clr(state != ACCESS),
    .en(state == ACCESS && !ack),
    .expire(expire)
  );
`else
  assign expire = 1'b0 && TIMEOUT_CYCLES != 0;
`endif
  // request accept, strobe hold until ack/abort, response hold until taken; write_o doubles as the latched we
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_rdata <= '0;
      write_o <= 1'b0;
      read_o <= 1'b0;
      addr_o <= '0;
      data_o <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          state <= ACCESS;
          req_ready <= 1'b0;
          write_o <= req_we;
          read_o <= !req_we;
          addr_o <= req_addr;
          data_o <= req_we ? req_wdata : '0;
        end
        ACCESS: if (ack || expire) begin
          state <= RESP;
          write_o <= 1'b0;
          read_o <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err <= !ack;
          rsp_rdata <= write_o ? '0 : ack ? data_i : ERR_DATA;
        end
        RESP: if (rsp_ready) begin
          state <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mm_bus_master.sv
// tb_mm_bus_master: table-driven transactions against a wait-state bus responder with a response scoreboard
module tb_mm_bus_master;
  import mm_bus_pkg::*;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0, force_ack = 1'b0;
  logic req_ready, rsp_valid, rsp_err, write_o, read_o, ack_i;
  logic [31:0] req_addr = '0, req_wdata = '0, bus_data = '0;
  logic [31:0] rsp_rdata, addr_o, data_o, data_i;
  int ack_after = 0, strobe_cnt = 0, n_chk = 0, n_err = 0;
  typedef struct {logic [31:0] rdata; logic err;} exp_t;
  typedef struct {
    mm_req_t req;
    logic [31:0] bus_data;
    int ack_after;
    int stall;
    logic [31:0] exp_rdata;
    logic exp_err;
    int exp_strobes;
    int exp_lat;
  } vec_t;
  exp_t sb_q[$];
  vec_t vecs[$];
  always #5 clk = ~clk;
  mm_bus_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .write_o(write_o), .read_o(read_o), .addr_o(addr_o), .data_o(data_o),
    .data_i(data_i), .ack_i(ack_i)
  );
  always @(posedge clk) strobe_cnt <= (read_o | write_o) ? strobe_cnt + 1 : 0;
  assign data_i = bus_data;
  assign ack_i = force_ack | ((read_o | write_o) && ack_after != 0 && strobe_cnt == ack_after - 1);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat, strobes;
    exp_t e;
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_we = v.req.we;
    req_addr = v.req.addr;
    req_wdata = v.req.wdata;
    bus_data = v.bus_data;
    ack_after = v.ack_after;
    sb_q.push_back('{v.exp_rdata, v.exp_err});
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = 32'h0BAD_0BAD;
    lat = 1;
    strobes = 0;
    while (!rsp_valid && lat < 300) begin
      if (read_o | write_o) begin
        strobes++;
        chk("addr_o", addr_o, v.req.addr);
        chk("data_o", data_o, v.req.we ? v.req.wdata : 32'h0);
        chk("write_o", write_o, v.req.we);
        chk("read_o", read_o, !v.req.we);
        chk("req_ready_busy", req_ready, 0);
      end
      @(negedge clk);
      lat++;
    end
    chk("rsp_latency", lat, v.exp_lat);
    chk("strobe_cycles", strobes, v.exp_strobes);
    chk("strobe_off_resp", read_o | write_o, 0);
    e = '{32'h0, 1'b0};
    if (sb_q.size() == 0) chk("sb_nonempty", 0, 1);
    else begin
      e = sb_q.pop_front();
      chk("rsp_rdata", rsp_rdata, e.rdata);
      chk("rsp_err", rsp_err, e.err);
    end
    for (int i = 0; i < v.stall; i++) begin
      force_ack = 1'b1;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_rdata", rsp_rdata, e.rdata);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_strobe", read_o | write_o, 0);
      @(negedge clk);
    end
    force_ack = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_done_valid", rsp_valid, 0);
  endtask

  initial begin
    vecs.push_back('{'{1'b1, LED_BASE, 32'h3FF}, 32'h0, 1, 0, 32'h0, 1'b0, 1, 2});
    vecs.push_back('{'{1'b0, SW_BASE, 32'h0}, 32'h0000_02A5, 1, 0, 32'h0000_02A5, 1'b0, 1, 2});
    vecs.push_back('{'{1'b0, 32'h4000_0010, 32'h0}, 32'h1234_5678, 4, 0, 32'h1234_5678, 1'b0, 4, 5});
    vecs.push_back('{'{1'b1, 32'h4000_0013, 32'hA5A5_A5A5}, 32'hFFFF_FFFF, 4, 0, 32'h0, 1'b0, 4, 5});
    vecs.push_back('{'{1'b0, UART_BASE, 32'h0}, 32'hCAFE_F00D, 1, 3, 32'hCAFE_F00D, 1'b0, 1, 2});
    vecs.push_back('{'{1'b0, 32'h4000_0104, 32'h0}, 32'h0000_0055, 8, 0, 32'h0000_0055, 1'b0, 8, 9});
`ifdef MM_TIMEOUT_EN
    vecs.push_back('{'{1'b0, 32'h4000_0300, 32'h0}, 32'h1111_1111, 0, 0, 32'hDEAD_BEEF, 1'b1, 8, 9});
    vecs.push_back('{'{1'b1, 32'h4000_0304, 32'h7777}, 32'h1111_1111, 0, 1, 32'h0, 1'b1, 8, 9});
`else
    vecs.push_back('{'{1'b0, 32'h4000_0300, 32'h0}, 32'h1357_9BDF, 12, 0, 32'h1357_9BDF, 1'b0, 12, 13});
`endif
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_write_o", write_o, 0);
    chk("rst_read_o", read_o, 0);
    chk("rst_addr_o", addr_o, 0);
    chk("rst_data_o", data_o, 0);
    rst = 1'b0;
    @(negedge clk);
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    chk("idle_ack_ignored", rsp_valid, 0);
    foreach (vecs[i]) run_vec(vecs[i]);
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 32'h4000_0020;
    ack_after = 0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_read_high", read_o, 1);
    @(negedge clk);
    chk("mid_read_wait", read_o, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_read_o", read_o, 0);
    chk("mid_rst_write_o", write_o, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    force_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("late_ack_valid", rsp_valid, 0);
      chk("late_ack_strobe", read_o | write_o, 0);
    end
    force_ack = 1'b0;
    @(negedge clk);
    run_vec(vecs[1]);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mm_bus_master.md
Name: mm_bus_master

Overview:
- Initiator side of the on-chip memory-mapped peripheral bus: the `write`/`read`/`addr`/`data`/`ack` bus that LED, switch and similar `*_mm` responders decode.
- Accepts single read/write requests from a core-side valid/ready port and drives one bus transaction at a time.
- Holds the strobes until a responder acks, then returns read data or write completion on a valid/ready response port.
- Sits between the CPU load/store unit and the shared peripheral bus; one instance per bus.

Parameters:
- ADDR_W, 32, bus address width.
- DATA_W, 32, bus data width.
- TIMEOUT_CYCLES, 256, cycles spent in ACCESS without ack before abort (used only with MM_TIMEOUT_EN).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on a timed-out read.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  DATA_W  read data (0 for writes).
- rsp_err  out  1  transaction timed out.
- write_o  out  1  bus write strobe.
- read_o  out  1  bus read strobe.
- addr_o  out  ADDR_W  bus address.
- data_o  out  DATA_W  bus write data.
- data_i  in  DATA_W  bus read data, resolved from responder tri-states.
- ack_i  in  1  bus acknowledge, resolved from responder tri-states; anything other than 1 (0/X/Z) counts as no ack.

Behaviour:
- Reset (rst high at a clk edge): state = IDLE.
- Outputs in reset: req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, write_o=0, read_o=0, addr_o=0, data_o=0, timeout counter=0.
- Reset mid-transaction: strobes drop on the next edge; any pending response is discarded.
- FSM IDLE:
  - req_ready=1 and strobes low.
  - On req_valid: latch we/addr/wdata, go ACCESS.
- FSM ACCESS:
  - req_ready=0.
  - read_o = ~we and write_o = we; exactly one strobe high in every ACCESS cycle.
  - addr_o and data_o are held constant from the latched registers; data_o = 0 on reads.
  - Responders ack combinationally, so ack_i is sampled in the same cycle the strobes are high.
  - On ack_i==1: capture data_i (reads) or 0 (writes) into rsp_rdata, rsp_err=0, go RESP.
  - Strobes are registered and deassert at the edge that leaves ACCESS; exactly one-cycle strobe when ack is immediate.
- FSM RESP:
  - rsp_valid=1; rsp_rdata and rsp_err stable.
  - Strobes low, req_ready=0.
  - On rsp_ready: go IDLE.
  - A new request can be accepted the cycle after the response handshake.
- Latency with zero-wait responder:
  - request accepted at edge N.
  - strobe high in cycle N+1, ack in the same cycle.
  - rsp_valid high from edge N+2.
  - Throughput: one transaction per 3 cycles minimum.
- Address: passed unmodified; the low two bits are not checked, masked or aligned.
- Simultaneous events: none are possible, because req_ready and rsp_valid are never high together.
- ack_i while not in ACCESS: ignored.
- A wait-stated responder (ack late): strobes stay high, address and data stay stable, no cycle limit unless MM_TIMEOUT_EN is defined.

Optional Feature:
- Macro: MM_TIMEOUT_EN.
- Defined:
  - Counter clears on entering ACCESS and increments each ACCESS cycle without ack.
  - When it reaches TIMEOUT_CYCLES-1 with no ack: go RESP with rsp_err=1 and rsp_rdata = ERR_DATA for reads, 0 for writes.
  - An ack in the final counted cycle wins; rsp_err=0.
- Undefined:
  - No counter.
  - rsp_err is tied 0.
  - ACCESS waits indefinitely for ack.

Decomposition:
- Package mm_bus_pkg:
  - state enum {IDLE, ACCESS, RESP}
  - MM_ADDR_W / MM_DATA_W defaults
  - struct mm_req_t {we, addr, wdata}
  - peripheral base-address constants, including LED base 32'h4000_0000
- Sub-module mm_timeout_ctr: clear/enable/expire counter, instantiated only under MM_TIMEOUT_EN.
- FSM and datapath stay in mm_bus_master.

Test Plan:
- Write, immediate ack: req write addr 0x4000_0000, wdata 0x3FF → write_o=1 for exactly one cycle with addr_o=0x4000_0000 and data_o=0x3FF; then rsp_valid with rdata=0, err=0, 2 cycles after accept.
- Read, immediate ack: bus model returns 0x0000_02A5 → rsp_rdata=0x0000_02A5, read_o high one cycle, write_o never high.
- Wait states: responder acks on the 4th strobe cycle → strobe high 4 cycles with stable addr/data; rsp_valid 5 cycles after accept.
- Backpressure: rsp_ready low 3 cycles → rsp_valid and rsp_rdata held, req_ready=0 throughout, no new strobe.
- Timeout (MM_TIMEOUT_EN, TIMEOUT_CYCLES=8), no responder (ack Z) → strobes high 8 cycles; rsp_err=1, rsp_rdata=0xDEAD_BEEF on a read.
- Reset mid-ACCESS: assert rst during a wait-state read → next edge strobes=0, req_ready=1, rsp_valid=0; a later ack is ignored.
